imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Boot-time writer for the instruction memory. Word index is addr[31:2]; the memory is 32 words deep by default.
- Accepts a byte stream over a valid/ready handshake, for example from a UART receiver.
- Assembles little-endian 32-bit instruction words and drives a one-cycle write strobe into the instruction memory write port.
- Holds the CPU in reset until a complete program has been loaded.

Parameters:
- MEM_DEPTH, 32, number of 32-bit words in instruction memory; legal header word counts are 1..MEM_DEPTH.
- ADDR_W, 32, width of the byte address driven on waddr.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle request to begin a load; honoured only in IDLE, DONE or ERR.
- rx_data  input  8  incoming stream byte.
- rx_valid  input  1  rx_data is valid.
- rx_ready  output  1  loader can accept a byte this cycle.
- we  output  1  instruction memory write strobe, one cycle per word.
- waddr  output  ADDR_W  byte address of the write, word aligned (bits [1:0] = 0).
- wdata  output  32  instruction word to write.
- busy  output  1  a load is in progress (HDR, DATA or WRITE).
- done  output  1  the last load completed successfully; sticky.
- error  output  1  the last load aborted on a bad header; sticky.
- cpu_hold  output  1  keeps the CPU in reset; high until done.
- words_loaded  output  8  count of words written in the current or last load.

Behaviour:
- States: IDLE, HDR, DATA, WRITE, DONE, ERR.
- Reset (asynchronous, any state):
  - State goes to IDLE.
  - rx_ready, we, busy, done and error = 0.
  - waddr, wdata and words_loaded = 0.
  - cpu_hold = 1.
  - Memory contents are not touched.
  - A reset in the middle of a load drops all partial data; a new start is required.
- A byte transfer occurs on a rising edge where rx_valid && rx_ready. rx_ready is combinational from state: 1 in HDR and DATA only.
- IDLE:
  - start goes to HDR.
  - Clear done, error, words_loaded and the byte counter.
- HDR:
  - The first accepted byte is N, the number of words.
  - If N == 0 or N > MEM_DEPTH, go to ERR.
  - Otherwise latch N and go to DATA.
- DATA:
  - Accepted byte k (k = 0..3) goes to wdata[8k+7:8k]; byte 0 is the least significant byte.
  - After the 4th accepted byte, go to WRITE on the same edge.
  - Missing rx_valid cycles stall indefinitely; there is no timeout.
- WRITE (exactly one cycle):
  - we = 1, waddr = words_loaded << 2, wdata = the assembled word.
  - On exit, words_loaded increments.
  - If the new words_loaded == N, go to DONE; else return to DATA with the byte counter at 0.
  - rx_ready = 0 in this state, so no byte can be lost.
- DONE:
  - done = 1 and cpu_hold = 0, both registered; they take effect the cycle after the final we.
  - start goes to HDR, which re-asserts cpu_hold and clears done on that edge.
- ERR:
  - error = 1; cpu_hold stays 1; words_loaded = 0.
  - start goes to HDR and clears error.
- start is ignored in HDR, DATA and WRITE.
- we, waddr and wdata are registered. Outside WRITE, we = 0 and waddr/wdata hold their last values.
- words_loaded is 8 bits; waddr is zero-extended to ADDR_W. The maximum waddr is (MEM_DEPTH-1)*4, so addresses never wrap.

Decomposition:
- Shared package rv32i_boot_pkg holds:
  - typedef enum logic [2:0] loader_state_t.
  - localparam WORD_BYTES = 4.
  - the header encoding constant HDR_BYTES = 1.
- Optional sub-module byte_packer: shift-in of 4 bytes to a 32-bit word plus a full flag. The FSM, counters and outputs stay in imem_loader.

Test Plan:
- Two-word load:
  - Stimulus: reset, start, then bytes 02, B3 82 41 00, B3 03 94 40.
  - Required: we pulses at waddr 0x0 with wdata 0x004182B3, then at 0x4 with 0x409403B3.
  - Next cycle: done = 1, cpu_hold = 0, words_loaded = 2.
- Bad header:
  - Header 00 gives error = 1, no we, cpu_hold = 1.
  - Header 0x21 (33 > MEM_DEPTH) gives the same result.
  - A following start plus a valid stream loads normally and clears error.
- Throttled stream:
  - rx_valid toggles every other cycle while loading 1 word (01, 13 00 00 00).
  - Required: a single we with wdata 0x00000013 at waddr 0x0; no byte is duplicated or lost; rx_ready = 0 during WRITE.
- Reset mid-load:
  - Assert reset after header 03 and 6 data bytes.
  - Required: all outputs return to reset values at once (asynchronously); a subsequent full 1-word load writes waddr 0x0.
- Ignored start and full-depth load:
  - Pulse start during DATA; it has no effect.
  - Load 32 words with value i in word i: the last we has waddr 0x7C, wdata 0x0000001F, then done = 1.

Source files
------------

// File: rtl/rv32i_boot_pkg.sv
// Shared types and constants for the boot-time instruction memory loader.
package rv32i_boot_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_HDR   = 3'd1,
      ST_DATA  = 3'd2,
      ST_WRITE = 3'd3,
      ST_DONE  = 3'd4,
      ST_ERR   = 3'd5
   } loader_state_t;

   localparam int unsigned WORD_BYTES = 4;
   localparam int unsigned HDR_BYTES  = 1;

endpackage

// File: rtl/byte_packer.sv
// Shifts stream bytes into a little-endian 32-bit word; full_c flags the push
// that completes the word, and word_c is the word including that byte.
module byte_packer
   import rv32i_boot_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        clr,
   input  logic        push,
   input  logic [7:0]  byte_in,
   output logic [31:0] word_c,
   output logic        full_c
);

   localparam int unsigned CNT_W = $clog2(WORD_BYTES);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]      word_q, word_d;

   // Newest byte enters at the top, so byte 0 ends up in bits [7:0].
   always_comb begin
      word_c = {byte_in, word_q[31:8]};
      full_c = push && (cnt_q == CNT_W'(WORD_BYTES - 1));
      cnt_d  = cnt_q;
      word_d = word_q;
      if (clr) begin
         cnt_d = '0;
      end else if (push) begin
         word_d = word_c;
         cnt_d  = full_c ? '0 : cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q  <= '0;
         word_q <= '0;
      end else begin
         cnt_q  <= cnt_d;
         word_q <= word_d;
      end
   end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: takes a word-count header byte then little-endian words from a
// byte stream, writes them to instruction memory and releases the CPU when done.
module imem_loader
   import rv32i_boot_pkg::*;
#(
   parameter int unsigned MEM_DEPTH = 32,
   parameter int unsigned ADDR_W    = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              rx_ready,
   output logic              we,
   output logic [ADDR_W-1:0] waddr,
   output logic [31:0]       wdata,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic              cpu_hold,
   output logic [7:0]        words_loaded
);

   loader_state_t     state_q, state_d;
   logic [7:0]        n_q, n_d;
   logic [7:0]        words_q, words_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] waddr_q, waddr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              error_q, error_d;
   logic              cpu_hold_q, cpu_hold_d;

   logic              push_c;
   logic              pk_clr_c;
   logic              pk_full_c;
   logic [31:0]       pk_word_c;

   assign rx_ready = (state_q == ST_HDR) || (state_q == ST_DATA);
   assign push_c   = rx_valid && rx_ready;

   byte_packer u_packer (
      .clk     (clk),
      .reset   (reset),
      .clr     (pk_clr_c),
      .push    (push_c && (state_q == ST_DATA)),
      .byte_in (rx_data),
      .word_c  (pk_word_c),
      .full_c  (pk_full_c)
   );

   always_comb begin
      state_d    = state_q;
      n_d        = n_q;
      words_d    = words_q;
      we_d       = 1'b0;
      waddr_d    = waddr_q;
      wdata_d    = wdata_q;
      done_d     = done_q;
      error_d    = error_q;
      cpu_hold_d = cpu_hold_q;
      pk_clr_c   = 1'b0;

      case (state_q)
         ST_IDLE, ST_DONE, ST_ERR: begin
            if (start) begin
               state_d    = ST_HDR;
               done_d     = 1'b0;
               error_d    = 1'b0;
               words_d    = '0;
               cpu_hold_d = 1'b1;
               pk_clr_c   = 1'b1;
            end
         end
         ST_HDR: begin
            if (push_c) begin
               if ((rx_data == 8'd0) || (32'(rx_data) > MEM_DEPTH)) begin
                  state_d = ST_ERR;
                  error_d = 1'b1;
                  words_d = '0;
               end else begin
                  state_d = ST_DATA;
                  n_d     = rx_data;
               end
            end
         end
         ST_DATA: begin
            // Register the write so the strobe lines up with the WRITE state.
            if (pk_full_c) begin
               state_d = ST_WRITE;
               we_d    = 1'b1;
               waddr_d = ADDR_W'({words_q, 2'b00});
               wdata_d = pk_word_c;
            end
         end
         ST_WRITE: begin
            words_d = words_q + 8'd1;
            if (words_d == n_q) begin
               state_d    = ST_DONE;
               done_d     = 1'b1;
               cpu_hold_d = 1'b0;
            end else begin
               state_d = ST_DATA;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      busy_d = (state_d == ST_HDR) || (state_d == ST_DATA) || (state_d == ST_WRITE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         n_q        <= '0;
         words_q    <= '0;
         we_q       <= 1'b0;
         waddr_q    <= '0;
         wdata_q    <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
         cpu_hold_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         n_q        <= n_d;
         words_q    <= words_d;
         we_q       <= we_d;
         waddr_q    <= waddr_d;
         wdata_q    <= wdata_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         error_q    <= error_d;
         cpu_hold_q <= cpu_hold_d;
      end
   end

   assign we           = we_q;
   assign waddr        = waddr_q;
   assign wdata        = wdata_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign error        = error_q;
   assign cpu_hold     = cpu_hold_q;
   assign words_loaded = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: loads, bad headers, throttling, mid-load reset.
module tb_imem_loader;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic        we;
   logic [31:0] waddr;
   logic [31:0] wdata;
   logic        busy;
   logic        done;
   logic        error;
   logic        cpu_hold;
   logic [7:0]  words_loaded;

   int n_checks = 0;
   int n_fail   = 0;
   int ready_in_write = 0;

   logic [31:0] wa_q[$];
   logic [31:0] wd_q[$];

   imem_loader #(.MEM_DEPTH(32), .ADDR_W(32)) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .rx_data      (rx_data),
      .rx_valid     (rx_valid),
      .rx_ready     (rx_ready),
      .we           (we),
      .waddr        (waddr),
      .wdata        (wdata),
      .busy         (busy),
      .done         (done),
      .error        (error),
      .cpu_hold     (cpu_hold),
      .words_loaded (words_loaded)
   );

   always #5 clk = ~clk;

   // Log every write strobe and flag any cycle that is writing and accepting.
   always @(negedge clk) begin
      if (we === 1'b1) begin
         wa_q.push_back(waddr);
         wd_q.push_back(wdata);
         if (rx_ready !== 1'b0) ready_in_write++;
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n;
      n = 0;
      rx_data  = b;
      rx_valid = 1'b1;
      while (rx_ready !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (rx_ready !== 1'b1) check_eq("rx_ready_timeout", 32'(rx_ready), 32'd1);
      @(posedge clk);
      #1 rx_valid = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w, input bit throttle);
      for (int k = 0; k < 4; k++) begin
         send_byte(w[8*k +: 8]);
         if (throttle) begin
            @(posedge clk);
            #1;
         end
      end
   endtask

   task automatic clear_log();
      wa_q.delete();
      wd_q.delete();
   endtask

   initial begin
      reset    = 1'b1;
      start    = 1'b0;
      rx_data  = 8'h00;
      rx_valid = 1'b0;
      repeat (3) @(negedge clk);

      // Reset values
      check_eq("rst_rx_ready", 32'(rx_ready), 32'd0);
      check_eq("rst_we", 32'(we), 32'd0);
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_done", 32'(done), 32'd0);
      check_eq("rst_error", 32'(error), 32'd0);
      check_eq("rst_cpu_hold", 32'(cpu_hold), 32'd1);
      check_eq("rst_waddr", waddr, 32'h0);
      check_eq("rst_wdata", wdata, 32'h0);
      check_eq("rst_words", 32'(words_loaded), 32'd0);
      reset = 1'b0;

      // Two-word load
      clear_log();
      pulse_start();
      check_eq("t1_busy_hdr", 32'(busy), 32'd1);
      check_eq("t1_ready_hdr", 32'(rx_ready), 32'd1);
      send_byte(8'h02);
      send_word(32'h004182B3, 1'b0);
      send_word(32'h409403B3, 1'b0);
      @(negedge clk);
      check_eq("t1_we_last", 32'(we), 32'd1);
      check_eq("t1_ready_write", 32'(rx_ready), 32'd0);
      check_eq("t1_done_not_yet", 32'(done), 32'd0);
      @(negedge clk);
      check_eq("t1_done", 32'(done), 32'd1);
      check_eq("t1_cpu_hold", 32'(cpu_hold), 32'd0);
      check_eq("t1_words", 32'(words_loaded), 32'd2);
      check_eq("t1_busy", 32'(busy), 32'd0);
      check_eq("t1_nwrites", 32'(wa_q.size()), 32'd2);
      check_eq("t1_waddr0", wa_q[0], 32'h0);
      check_eq("t1_wdata0", wd_q[0], 32'h004182B3);
      check_eq("t1_waddr1", wa_q[1], 32'h4);
      check_eq("t1_wdata1", wd_q[1], 32'h409403B3);

      // Bad header 0x00, then 0x21
      clear_log();
      pulse_start();
      check_eq("t2_done_cleared", 32'(done), 32'd0);
      check_eq("t2_hold_reassert", 32'(cpu_hold), 32'd1);
      send_byte(8'h00);
      @(negedge clk);
      check_eq("t2_err0", 32'(error), 32'd1);
      check_eq("t2_hold0", 32'(cpu_hold), 32'd1);
      check_eq("t2_busy0", 32'(busy), 32'd0);
      check_eq("t2_words0", 32'(words_loaded), 32'd0);
      pulse_start();
      check_eq("t2_err_clr_a", 32'(error), 32'd0);
      send_byte(8'h21);
      @(negedge clk);
      check_eq("t2_err21", 32'(error), 32'd1);
      check_eq("t2_hold21", 32'(cpu_hold), 32'd1);
      check_eq("t2_nwrites", 32'(wa_q.size()), 32'd0);
      pulse_start();
      check_eq("t2_err_clr_b", 32'(error), 32'd0);
      send_byte(8'h01);
      send_word(32'h12345678, 1'b0);
      repeat (2) @(negedge clk);
      check_eq("t2_done", 32'(done), 32'd1);
      check_eq("t2_error_after", 32'(error), 32'd0);
      check_eq("t2_nwrites_ok", 32'(wa_q.size()), 32'd1);
      check_eq("t2_wdata", wd_q[0], 32'h12345678);

      // Throttled stream
      clear_log();
      pulse_start();
      send_byte(8'h01);
      @(posedge clk);
      #1;
      send_word(32'h00000013, 1'b1);
      repeat (3) @(negedge clk);
      check_eq("t3_nwrites", 32'(wa_q.size()), 32'd1);
      check_eq("t3_waddr", wa_q[0], 32'h0);
      check_eq("t3_wdata", wd_q[0], 32'h00000013);
      check_eq("t3_done", 32'(done), 32'd1);
      check_eq("t3_words", 32'(words_loaded), 32'd1);

      // Reset mid-load after header 03 and six data bytes
      clear_log();
      pulse_start();
      send_byte(8'h03);
      send_word(32'hA1A2A3A4, 1'b0);
      send_byte(8'hB4);
      send_byte(8'hB3);
      @(negedge clk);
      check_eq("t4_words_pre", 32'(words_loaded), 32'd1);
      #1 reset = 1'b1;
      #1;
      check_eq("t4_rst_busy", 32'(busy), 32'd0);
      check_eq("t4_rst_ready", 32'(rx_ready), 32'd0);
      check_eq("t4_rst_hold", 32'(cpu_hold), 32'd1);
      check_eq("t4_rst_waddr", waddr, 32'h0);
      check_eq("t4_rst_wdata", wdata, 32'h0);
      check_eq("t4_rst_words", 32'(words_loaded), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      clear_log();
      pulse_start();
      send_byte(8'h01);
      send_word(32'hDDCCBBAA, 1'b0);
      repeat (2) @(negedge clk);
      check_eq("t4_nwrites", 32'(wa_q.size()), 32'd1);
      check_eq("t4_waddr", wa_q[0], 32'h0);
      check_eq("t4_wdata", wd_q[0], 32'hDDCCBBAA);
      check_eq("t4_done", 32'(done), 32'd1);

      // Full-depth load with an ignored start inside DATA
      clear_log();
      pulse_start();
      send_byte(8'h20);
      send_byte(8'h00);
      send_byte(8'h00);
      pulse_start();
      check_eq("t5_busy_ign", 32'(busy), 32'd1);
      check_eq("t5_ready_ign", 32'(rx_ready), 32'd1);
      send_byte(8'h00);
      send_byte(8'h00);
      for (int i = 1; i < 32; i++) send_word(32'(i), 1'b0);
      repeat (2) @(negedge clk);
      check_eq("t5_nwrites", 32'(wa_q.size()), 32'd32);
      for (int i = 0; i < 32; i++) begin
         check_eq($sformatf("t5_waddr%0d", i), wa_q[i], 32'(i * 4));
         check_eq($sformatf("t5_wdata%0d", i), wd_q[i], 32'(i));
      end
      check_eq("t5_done", 32'(done), 32'd1);
      check_eq("t5_hold", 32'(cpu_hold), 32'd0);
      check_eq("t5_words", 32'(words_loaded), 32'd32);
      check_eq("ready_in_write", 32'(ready_in_write), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
